// File: rtl/pll_lock_mgr.sv
// pll_lock_mgr: reset/lock sequencer for the fabric PLL, clocked by refclk.
// Holds the PLL in reset, waits for and debounces lock, then releases sys_rst.
// Loss of lock in RUN re-runs the whole sequence.
// Optional feature: define PLL_LOCK_LOSS_CNT_EN to build the saturating
// loss_count counter; otherwise loss_count is tied to zero.
module pll_lock_mgr #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILTER  = 256,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int CNT_W        = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             force_reset,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [1:0]       state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] loss_count
);

  // One shared counter serves all states, so it is sized for the largest limit.
  localparam int MAX_A = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES : LOCK_FILTER;
  localparam int MAX_V = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CW    = (MAX_V > 1) ? $clog2(MAX_V) : 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_FILTER    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          timeout_set;
  logic          lk_meta, lk_s;

  assign state = state_reg;

  // Lock synchroniser. pll_locked is stale while the PLL is held in reset, so
  // the flops are flushed during RESET and start sampling on the cycle pll_rst
  // is released; lock then reaches the FSM two cycles after pll_rst falls.
  always_ff @(posedge refclk) begin
    if (rst || state_next == ST_RESET) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  // Next-state and counter logic; force_reset overrides every state.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    timeout_set = 1'b0;
    if (force_reset) begin
      state_next = ST_RESET;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_RESET: begin
          if (cnt_reg == RST_LAST) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock arriving on the final timeout cycle takes precedence.
          if (lk_s) begin
            state_next = ST_FILTER;
            cnt_next   = '0;
          end else if (cnt_reg == TO_LAST) begin
            state_next  = ST_RESET;
            cnt_next    = '0;
            timeout_set = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_FILTER: begin
          if (!lk_s) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == FILT_LAST) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          if (!lk_s) begin
            state_next = ST_RESET;
            cnt_next   = '0;
          end
        end
      endcase
    end
  end

  // State register plus outputs registered from the next state, so they move
  // in the same cycle as state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg   <= ST_RESET;
      cnt_reg     <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pll_rst   <= (state_next == ST_RESET);
      sys_rst   <= (state_next != ST_RUN);
      ready     <= (state_next == ST_RUN);
      if (force_reset) begin
        timeout_err <= 1'b0;
      end else if (timeout_set) begin
        timeout_err <= 1'b1;
      end
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  // A loss is lock dropping while in RUN; it counts even when force_reset
  // arrives in the same cycle.
  logic loss_event;
  assign loss_event = (state_reg == ST_RUN) && !lk_s;

  // Saturating loss counter; only rst clears it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_count <= '0;
    end else if (loss_event && (loss_count != {CNT_W{1'b1}})) begin
      loss_count <= loss_count + 1'b1;
    end
  end
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Directed bench for pll_lock_mgr with RST_CYCLES=4, LOCK_FILTER=8,
// LOCK_TIMEOUT=32, CNT_W=8. Works with or without PLL_LOCK_LOSS_CNT_EN.
module tb_pll_lock_mgr;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b1;
  logic       force_reset = 1'b0;
  logic       pll_rst, sys_rst, ready, timeout_err;
  logic [1:0] state;
  logic [7:0] loss_count;

  int checks = 0;
  int errors = 0;
  int n;

`ifdef PLL_LOCK_LOSS_CNT_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  pll_lock_mgr #(
    .RST_CYCLES(4), .LOCK_FILTER(8), .LOCK_TIMEOUT(32), .CNT_W(8)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .force_reset(force_reset),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .state(state),
    .timeout_err(timeout_err), .loss_count(loss_count)
  );

  always #5 refclk = ~refclk;

  function automatic logic [31:0] lc(input int v);
    return LC_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_pll_rst(input logic v, output int cnt);
    cnt = 0;
    while (pll_rst !== v && cnt < 200) begin tick(); cnt++; end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 200) begin tick(); cnt++; end
  endtask

  task automatic wait_state(input logic [1:0] s, output int cnt);
    cnt = 0;
    while (state !== s && cnt < 200) begin tick(); cnt++; end
  endtask

  initial begin
    // Reset values
    ticks(3);
    check("rst_state", 32'(state), 0);
    check("rst_pll_rst", 32'(pll_rst), 1);
    check("rst_sys_rst", 32'(sys_rst), 1);
    check("rst_ready", 32'(ready), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_loss", 32'(loss_count), 0);
    $display("txn power-up reset: state=%0d pll_rst=%0d", state, pll_rst);

    // Power-up with lock present from the start
    rst = 1'b0;
    wait_pll_rst(1'b0, n);
    check("pu_pll_rst_len", 32'(n), 4);
    check("pu_state_wait", 32'(state), 1);
    wait_ready(n);
    check("pu_ready_lat", 32'(n), 10);
    check("pu_sys_rst", 32'(sys_rst), 0);
    check("pu_state_run", 32'(state), 3);
    $display("txn power-up lock: ready after %0d cycles", n);

    // Lock lost in RUN
    ticks(2);
    pll_locked = 1'b0;
    ticks(2);
    check("loss_still_run", 32'(state), 3);
    tick();
    check("loss_state", 32'(state), 0);
    check("loss_sys_rst", 32'(sys_rst), 1);
    check("loss_ready", 32'(ready), 0);
    check("loss_pll_rst", 32'(pll_rst), 1);
    check("loss_count1", 32'(loss_count), lc(1));
    $display("txn lock loss: state=%0d loss_count=%0d", state, loss_count);

    // Lock stays away: timeout and periodic retry
    wait_pll_rst(1'b0, n);
    check("to_rst_len1", 32'(n), 4);
    check("to_err_before", 32'(timeout_err), 0);
    wait_pll_rst(1'b1, n);
    check("to_wait_len1", 32'(n), 32);
    check("to_err_set", 32'(timeout_err), 1);
    check("to_state", 32'(state), 0);
    wait_pll_rst(1'b0, n);
    check("to_rst_len2", 32'(n), 4);
    wait_pll_rst(1'b1, n);
    check("to_wait_len2", 32'(n), 32);
    $display("txn timeout retry: timeout_err=%0d", timeout_err);

    // One-cycle drop at filter count 5 restarts the filter
    pll_locked = 1'b1;
    wait_pll_rst(1'b0, n);
    check("gl_rst_len", 32'(n), 4);
    ticks(2);
    check("gl_in_filter", 32'(state), 2);
    ticks(3);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check("gl_filter_cnt5", 32'(state), 2);
    tick();
    check("gl_back_wait", 32'(state), 1);
    wait_ready(n);
    check("gl_refilter_lat", 32'(n), 9);
    check("gl_timeout_kept", 32'(timeout_err), 1);
    $display("txn filter glitch: ready after %0d cycles", n);

    // force_reset in RUN, then again in RESET
    force_reset = 1'b1;
    tick();
    force_reset = 1'b0;
    check("fr_state", 32'(state), 0);
    check("fr_timeout_clr", 32'(timeout_err), 0);
    check("fr_loss_kept", 32'(loss_count), lc(1));
    check("fr_ready", 32'(ready), 0);
    ticks(2);
    force_reset = 1'b1;
    tick();
    force_reset = 1'b0;
    wait_pll_rst(1'b0, n);
    check("fr_restart_len", 32'(n), 4);
    wait_ready(n);
    check("fr_relock_lat", 32'(n), 10);
    $display("txn force_reset: relocked after %0d cycles", n);

    // 300 further losses: counter saturates
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      wait_state(2'd0, n);
      check("sat_loss_lat", 32'(n), 3);
      pll_locked = 1'b1;
      wait_ready(n);
      check("sat_relock_lat", 32'(n), 14);
      if (i == 252) check("sat_254", 32'(loss_count), lc(254));
    end
    check("sat_255", 32'(loss_count), lc(255));
    $display("txn saturation: loss_count=%0d", loss_count);

    // rst asserted mid-FILTER
    pll_locked = 1'b0;
    wait_state(2'd0, n);
    check("mf_loss_lat", 32'(n), 3);
    pll_locked = 1'b1;
    wait_state(2'd2, n);
    check("mf_to_filter", 32'(n), 6);
    ticks(3);
    rst = 1'b1;
    pll_locked = 1'b0;
    tick();
    check("mf_state", 32'(state), 0);
    check("mf_pll_rst", 32'(pll_rst), 1);
    check("mf_sys_rst", 32'(sys_rst), 1);
    check("mf_ready", 32'(ready), 0);
    check("mf_timeout", 32'(timeout_err), 0);
    check("mf_loss", 32'(loss_count), 0);
    $display("txn rst mid-filter: state=%0d loss_count=%0d", state, loss_count);

    // Lock arriving on the final timeout cycle wins
    rst = 1'b0;
    wait_pll_rst(1'b0, n);
    check("tb_rst_len", 32'(n), 4);
    ticks(29);
    pll_locked = 1'b1;
    ticks(2);
    check("tb_still_wait", 32'(state), 1);
    tick();
    check("tb_to_filter", 32'(state), 2);
    check("tb_no_timeout", 32'(timeout_err), 0);
    wait_ready(n);
    check("tb_filter_len", 32'(n), 8);
    $display("txn lock on timeout cycle: state=%0d timeout_err=%0d", state, timeout_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
